// File: rtl/shift_pkg.sv
// Shared constants for the register-shift sequencer: shift-type codes and FSM encoding.
package shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between register read, the shift sequencer and the ALU operand-2 path.
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  // Both sides use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; the source holds valid and data stable until then.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_rm;
  logic [1:0]       in_type;
  logic [7:0]       in_amt;
  logic             in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_c;

  modport master (
    output in_valid, in_rm, in_type, in_amt, in_c, out_ready,
    input  in_ready, out_valid, out_result, out_c
  );

  modport slave (
    input  in_valid, in_rm, in_type, in_amt, in_c, out_ready,
    output in_ready, out_valid, out_result, out_c
  );
endinterface

// File: rtl/shift_step.sv
// Combinational one-position shifter; also usable by the immediate-shift path.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_type,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val,
  output logic             o_c
);

  always_comb begin
    o_val = i_val;
    o_c   = i_val[0];
    case (i_type)
      SH_LSL: begin
        o_val = {i_val[WIDTH-2:0], 1'b0};
        o_c   = i_val[WIDTH-1];
      end
      SH_LSR:  o_val = {1'b0, i_val[WIDTH-1:1]};
      SH_ASR:  o_val = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
      default: o_val = {i_val[0], i_val[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified shifter: one bit position per cycle, ARM carry semantics
// obtained by clamping the iteration count rather than by special-casing results.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus,
  output state_t           o_state
);

  localparam int          CW     = $clog2(WIDTH + 2);
  localparam logic [31:0] MAX_LS = 32'(WIDTH + 1);
  localparam logic [31:0] MAX_AS = 32'(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [1:0]       r_type;
  logic             r_carry;

  logic [31:0]      w_amt;
  logic [31:0]      w_rmod;
  logic [31:0]      w_n32;
  logic [CW-1:0]    w_n;
  logic             w_ror_wrap;
  logic             w_accept;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_c;

  assign w_amt    = {24'd0, bus.in_amt};
  assign w_rmod   = w_amt % MAX_AS;
  assign w_accept = bus.in_valid && (r_state == ST_IDLE);

  // Iteration count; LSL/LSR clamp at WIDTH+1 so the extra step flushes the carry to 0.
  always_comb begin
    w_n32      = w_amt;
    w_ror_wrap = 1'b0;
    case (bus.in_type)
      SH_LSL, SH_LSR: if (w_amt > MAX_LS) w_n32 = MAX_LS;
      SH_ASR:         if (w_amt > MAX_AS) w_n32 = MAX_AS;
      default: begin
        w_n32      = w_rmod;
        w_ror_wrap = (w_amt != 32'd0) && (w_rmod == 32'd0);
      end
    endcase
  end
  assign w_n = CW'(w_n32);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_type (r_type),
    .i_val  (r_work),
    .o_val  (w_step_val),
    .o_c    (w_step_c)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = (w_n == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (r_cnt == CW'(1)) w_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (r_state == ST_IDLE);
    bus.out_valid  = (r_state == ST_DONE);
    bus.out_result = r_work;
    bus.out_c      = r_carry;
    o_state        = r_state;
  end

  // A full-turn rotate leaves the value intact but still reports the MSB as carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work  <= '0;
      r_type  <= SH_LSL;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_work  <= bus.in_rm;
      r_type  <= bus.in_type;
      r_carry <= w_ror_wrap ? bus.in_rm[WIDTH-1] : bus.in_c;
      r_cnt   <= w_n;
    end else if (r_state == ST_SHIFT) begin
      r_work  <= w_step_val;
      r_carry <= w_step_c;
      r_cnt   <= r_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed ARM boundary cases plus randomized traffic.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  shift_sequencer_if #(.WIDTH(W)) bus ();
  state_t dbg_state;

  shift_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [W:0]  exp_q[$];   // {carry, result}
  int          lat_q[$];   // cycle index at which out_valid must first appear
  int          ready_mode = 0;  // 0: always ready, 1: hold low, 2: random

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (ARM register-shift rules) ----------------
  function automatic logic [W:0] model(input logic [W-1:0] rm, input logic [1:0] typ,
                                       input int amt, input logic cin);
    logic [W-1:0] r;
    logic         co;
    int           k;
    if (amt == 0) return {cin, rm};
    r  = '0;
    co = 1'b0;
    case (typ)
      2'd0: begin
        if (amt < W)       begin r = rm << amt; co = rm[W-amt]; end
        else if (amt == W) begin r = '0;        co = rm[0];     end
      end
      2'd1: begin
        if (amt < W)       begin r = rm >> amt; co = rm[amt-1]; end
        else if (amt == W) begin r = '0;        co = rm[W-1];   end
      end
      2'd2: begin
        if (amt < W) begin r = $signed(rm) >>> amt; co = rm[amt-1]; end
        else         begin r = {W{rm[W-1]}};        co = rm[W-1];   end
      end
      default: begin
        k = amt % W;
        if (k == 0) begin r = rm; co = rm[W-1]; end
        else begin r = (rm >> k) | (rm << (W - k)); co = rm[k-1]; end
      end
    endcase
    return {co, r};
  endfunction

  function automatic int model_lat(input logic [1:0] typ, input int amt);
    int n;
    case (typ)
      2'd0, 2'd1: n = (amt > W + 1) ? W + 1 : amt;
      2'd2:       n = (amt > W) ? W : amt;
      default:    n = amt % W;
    endcase
    return n + 1;
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [W-1:0] rm, input logic [1:0] typ, input int amt, input logic cin);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_rm    = rm;
    bus.in_type  = typ;
    bus.in_amt   = 8'(amt);
    bus.in_c     = cin;
    @(posedge clk);
    #1;
    exp_q.push_back(model(rm, typ, amt, cin));
    lat_q.push_back(cyc + model_lat(typ, amt) - 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: out_valid got 1 expected 0 (cycle %0d)", cyc);
          end else begin
            if (!prev_valid) check("latency", 32'(cyc), 32'(lat_q.pop_front()));
            check("result", bus.out_result, exp_q[0][W-1:0]);
            check("carry", 32'(bus.out_c), 32'(exp_q[0][W]));
            check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        prev_valid = bus.out_valid && !bus.out_ready;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] rm;
    int guard;
    bus.in_valid = 1'b0;
    bus.in_rm    = '0;
    bus.in_type  = 2'd0;
    bus.in_amt   = 8'd0;
    bus.in_c     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_c", 32'(bus.out_c), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // directed ARM boundary cases
    send(32'h4A75DF23, 2'd0, 4, 1'b0);
    send(32'h4A75DF23, 2'd1, 1, 1'b0);
    send(32'h00000001, 2'd0, 32, 1'b0);
    send(32'h00000001, 2'd0, 33, 1'b0);
    send(32'h00000001, 2'd0, 200, 1'b0);
    send(32'h80000000, 2'd1, 32, 1'b0);
    send(32'h80000001, 2'd2, 40, 1'b0);
    send(32'h4A75DF23, 2'd3, 8, 1'b0);
    send(32'h80000000, 2'd3, 32, 1'b0);
    send(32'h00000001, 2'd3, 64, 1'b1);
    for (int t = 0; t < 4; t++) send($urandom, 2'(t), 0, 1'b1);
    drain();

    // consumer back-pressure: result and valid must hold while out_ready is low
    ready_mode = 1;
    send(32'h12345678, 2'd1, 3, 1'b0);
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    ready_mode = 0;
    drain();

    // reset in the middle of a shift abandons the operation
    send(32'hDEADBEEF, 2'd0, 20, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    lat_q.delete();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_result", bus.out_result, 32'd0);
    check("midrst_out_c", 32'(bus.out_c), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_quiet", 32'(bus.out_valid), 32'd0);

    // randomized traffic with random consumer stalls
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      rm = $urandom;
      if ($urandom_range(0, 3) == 0)
        send(rm, 2'($urandom_range(0, 3)), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      else
        send(rm, 2'($urandom_range(0, 3)), $urandom_range(0, 40), 1'($urandom_range(0, 1)));
    end
    drain();
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
